// File: rtl/rr_req_pkg.sv
// Shared constants, client vector type and counter-width helper for the request tracker.
package rr_req_pkg;

  localparam int CLIENTS_DEF = 32;
  localparam int DEPTH_DEF   = 4;

  typedef logic [CLIENTS_DEF-1:0] client_vec_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_req_slot.sv
// One client's pending counter with ready/request decode.
// Age counter and starve flag are built only with RR_REQ_TRACKER_STARVE_EN.
module rr_req_slot
  import rr_req_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int CNT_W        = cnt_width(DEPTH),
  parameter int STARVE_LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic post,
  input  logic grant,
  input  logic stall,
  output logic post_ready,
  output logic request,
  output logic starve
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_reg;
  logic             acc;
  logic             ret;

  // Ready looks only at the registered count, so a same-cycle grant never frees a slot.
  assign post_ready = (count_reg < FULL);
  assign request    = (count_reg != '0);
  assign acc        = post & post_ready;
  assign ret        = grant & request;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (acc && !ret) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (!acc && ret) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

`ifdef RR_REQ_TRACKER_STARVE_EN
  localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      age_reg <= '0;
    end else if (ret || !request) begin
      age_reg <= '0;
    end else if (!stall && (age_reg != AGE_MAX)) begin
      age_reg <= age_reg + AGE_W'(1);
    end
  end

  assign starve = (age_reg == AGE_MAX);
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign starve       = 1'b0;
`endif

endmodule

// File: rtl/rr_req_tracker.sv
// Per-client pending-post tracker feeding rr_arbiter, with sticky protocol error flags.
// Optional starvation flags are enabled by defining RR_REQ_TRACKER_STARVE_EN.
module rr_req_tracker
  import rr_req_pkg::*;
#(
  parameter int CLIENTS      = CLIENTS_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int CNT_W        = cnt_width(DEPTH),
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] post,
  output logic [CLIENTS-1:0] post_ready,
  output logic [CLIENTS-1:0] request,
  input  logic [CLIENTS-1:0] grant,
  input  logic               stall,
  output logic               pending_any,
  output logic               overflow_err,
  output logic               spurious_err,
  output logic [CLIENTS-1:0] starve
);

  logic               overflow_reg;
  logic               spurious_reg;
  logic [CLIENTS-1:0] dropped;
  logic [CLIENTS-1:0] stray;
  logic               multi_grant;

  for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_slot
    rr_req_slot #(
      .DEPTH        (DEPTH),
      .CNT_W        (CNT_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .post       (post[gi]),
      .grant      (grant[gi]),
      .stall      (stall),
      .post_ready (post_ready[gi]),
      .request    (request[gi]),
      .starve     (starve[gi])
    );
  end

  assign dropped     = post & ~post_ready;
  assign stray       = grant & ~request;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_grant = ((grant & (grant - CLIENTS'(1))) != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      spurious_reg <= 1'b0;
    end else begin
      if (dropped != '0) overflow_reg <= 1'b1;
      if ((stray != '0) || multi_grant) spurious_reg <= 1'b1;
    end
  end

  assign pending_any  = |request;
  assign overflow_err = overflow_reg;
  assign spurious_err = spurious_reg;

endmodule

// File: tb/tb_rr_req_tracker.sv
// Directed plus random self-checking bench for rr_req_tracker against a counting reference model.
module tb_rr_req_tracker;
  import rr_req_pkg::*;

  localparam int CLIENTS = 32;
  localparam int DEPTH   = 4;
  localparam int LIMIT   = 64;

  logic        clock = 1'b0;
  logic        reset;
  client_vec_t post;
  client_vec_t grant;
  logic        stall;
  client_vec_t post_ready;
  client_vec_t request;
  logic        pending_any;
  logic        overflow_err;
  logic        spurious_err;
  client_vec_t starve;

  rr_req_tracker #(
    .CLIENTS      (CLIENTS),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .post         (post),
    .post_ready   (post_ready),
    .request      (request),
    .grant        (grant),
    .stall        (stall),
    .pending_any  (pending_any),
    .overflow_err (overflow_err),
    .spurious_err (spurious_err),
    .starve       (starve)
  );

  always #5 clock = ~clock;

  int cnt [CLIENTS];
  int age [CLIENTS];
  bit m_ovf;
  bit m_spur;
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    client_vec_t er, ep, es;
    for (int i = 0; i < CLIENTS; i++) begin
      er[i] = (cnt[i] != 0);
      ep[i] = (cnt[i] < DEPTH);
`ifdef RR_REQ_TRACKER_STARVE_EN
      es[i] = (age[i] == LIMIT);
`else
      es[i] = 1'b0;
`endif
    end
    chk({tag, ".request"}, request, er);
    chk({tag, ".post_ready"}, post_ready, ep);
    chk({tag, ".pending_any"}, 32'(pending_any), 32'(er != '0));
    chk({tag, ".overflow_err"}, 32'(overflow_err), 32'(m_ovf));
    chk({tag, ".spurious_err"}, 32'(spurious_err), 32'(m_spur));
    chk({tag, ".starve"}, starve, es);
  endtask

  // Advance one clock edge with the current inputs, update the model, then check.
  task automatic cycle(input string tag);
    int ones;
    ones = $countones(grant);
    if (reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        cnt[i] = 0;
        age[i] = 0;
      end
      m_ovf  = 0;
      m_spur = 0;
    end else begin
      if (ones > 1) m_spur = 1;
      for (int i = 0; i < CLIENTS; i++) begin
        bit has_req, acc, ret;
        has_req = (cnt[i] > 0);
        acc     = post[i] && (cnt[i] < DEPTH);
        ret     = grant[i] && has_req;
        if (post[i] && !acc) m_ovf = 1;
        if (grant[i] && !has_req) m_spur = 1;
        if (ret || !has_req) age[i] = 0;
        else if (!stall && age[i] < LIMIT) age[i] = age[i] + 1;
        cnt[i] = cnt[i] + int'(acc) - int'(ret);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    $display("cyc %0d %s rst=%0b post=%h grant=%h stall=%0b -> req=%h rdy=%h ovf=%0b spur=%0b",
             cyc, tag, reset, post, grant, stall, request, post_ready, overflow_err, spurious_err);
    check_all(tag);
  endtask

  task automatic idle();
    post  = '0;
    grant = '0;
    stall = 1'b0;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle("reset");
    reset = 1'b0;
  endtask

  initial begin
    client_vec_t r;
    int pick;
    m_ovf  = 0;
    m_spur = 0;
    for (int i = 0; i < CLIENTS; i++) begin
      cnt[i] = 0;
      age[i] = 0;
    end
    idle();
    reset = 1'b1;
    cycle("reset0");
    cycle("reset1");
    chk("reset.post_ready", post_ready, 32'hFFFF_FFFF);
    chk("reset.request", request, 32'h0);
    reset = 1'b0;

    // Single post on client 3
    post = 32'h8;
    cycle("t1_post");
    post = '0;
    chk("t1.request", request, 32'h8);
    chk("t1.pending_any", 32'(pending_any), 32'h1);
    chk("t1.ready3", 32'(post_ready[3]), 32'h1);
    cycle("t1_idle");

    // Fill client 5, then overflow it
    do_reset();
    for (int k = 0; k < 4; k++) begin
      post = 32'h20;
      cycle("t2_fill");
    end
    chk("t2.ready5", 32'(post_ready[5]), 32'h0);
    cycle("t2_over");
    post = '0;
    chk("t2.overflow", 32'(overflow_err), 32'h1);
    for (int k = 0; k < 4; k++) begin
      grant = 32'h20;
      cycle("t2_drain");
      chk("t2.req5", 32'(request[5]), (k < 3) ? 32'h1 : 32'h0);
    end
    grant = '0;
    cycle("t2_idle");

    // Client 7 at count 2 drained by two grants
    do_reset();
    post = 32'h80;
    cycle("t3_post");
    cycle("t3_post");
    post  = '0;
    grant = 32'h80;
    chk("t3.req_g1", 32'(request[7]), 32'h1);
    cycle("t3_grant");
    chk("t3.req_g2", 32'(request[7]), 32'h1);
    cycle("t3_grant");
    grant = '0;
    chk("t3.req_after", 32'(request[7]), 32'h0);
    chk("t3.noerr", {30'd0, overflow_err, spurious_err}, 32'h0);

    // Simultaneous post and grant on client 2 at count 1
    post = 32'h4;
    cycle("t4_post");
    grant = 32'h4;
    cycle("t4_both");
    post  = '0;
    grant = '0;
    chk("t4.req2", 32'(request[2]), 32'h1);
    grant = 32'h4;
    cycle("t4_drain");
    grant = '0;
    chk("t4.req2_off", 32'(request[2]), 32'h0);

    // Spurious and multi-hot grants
    do_reset();
    post = 32'h1;
    cycle("t5_post");
    post  = '0;
    grant = 32'h10;
    cycle("t5_spur");
    chk("t5.spur", 32'(spurious_err), 32'h1);
    grant = 32'h3;
    cycle("t5_multi");
    grant = '0;
    chk("t5.req", request, 32'h0);
    post = 32'h40;
    cycle("t5_more");
    post = '0;
    chk("t5.sticky", 32'(spurious_err), 32'h1);

    // Reset mid-operation discards everything
    post = 32'hFFFF_FFFF;
    cycle("t6_load");
    post = '0;
    do_reset();
    chk("t6.request", request, 32'h0);

`ifdef RR_REQ_TRACKER_STARVE_EN
    // Starvation on client 9, with one stalled cycle
    post = 32'h200;
    cycle("t7_post");
    post = '0;
    for (int k = 0; k < 64; k++) begin
      stall = (k == 10);
      cycle("t7_wait");
    end
    stall = 1'b0;
    chk("t7.not_yet", 32'(starve[9]), 32'h0);
    cycle("t7_wait");
    chk("t7.starve", 32'(starve[9]), 32'h1);
    grant = 32'h200;
    cycle("t7_grant");
    grant = '0;
    chk("t7.cleared", 32'(starve[9]), 32'h0);
`endif

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      post  = $urandom & $urandom & $urandom;
      stall = ($urandom_range(0, 3) == 0);
      reset = (k == 200);
      grant = '0;
      pick  = $urandom_range(0, 19);
      if (pick < 16) begin
        for (int i = 0; i < CLIENTS; i++) r[i] = (cnt[i] > 0);
        if (r != '0) begin
          int c;
          c = $urandom_range(0, CLIENTS - 1);
          while (!r[c]) c = (c + 1) % CLIENTS;
          grant[c] = 1'b1;
        end
      end else if (pick == 18) begin
        grant[$urandom_range(0, CLIENTS - 1)] = 1'b1;
      end else if (pick == 19) begin
        grant = $urandom & $urandom;
      end
      cycle("rand");
    end
    idle();
    cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_req_tracker.md
Name: rr_req_tracker

Overview:
- Upstream stage of rr_arbiter. Tracks pending transactions per client and drives the arbiter's request vector.
- request[i] rises once client i has at least one pending post. It stays high, unchanged, until grant[i] retires a post.
- This guarantees the arbiter's input contract: a request is never withdrawn before it is granted.
- Also flags protocol errors: overflow posts and spurious grants.

Parameters:
- CLIENTS, 32, number of clients; must match the rr_arbiter CLIENTS.
- DEPTH, 4, maximum pending posts per client (>=1).
- CNT_W, $clog2(DEPTH+1), width of each per-client pending counter (derived; do not override).
- STARVE_LIMIT, 64, cycles a request may wait ungranted before starve[i] asserts (used only with the optional feature).

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- post  input  CLIENTS  per-client one-cycle pulse: add one pending transaction.
- post_ready  output  CLIENTS  client i may post this cycle (count[i] < DEPTH).
- request  output  CLIENTS  to arbiter; request[i] = (count[i] != 0).
- grant  input  CLIENTS  from arbiter; one-hot or zero.
- stall  input  1  arbiter stall; informational only, gates the starve counters.
- pending_any  output  1  OR of request.
- overflow_err  output  1  sticky: a post arrived while post_ready was low.
- spurious_err  output  1  sticky: grant[i] arrived while request[i] was low, or grant was not onehot0.
- starve  output  CLIENTS  per-client starvation flag (optional feature; tied 0 when disabled).

Behaviour:
- Clock and reset: clock clock; reset reset, synchronous, active-high.
- Values after reset:
  - All counts are 0.
  - request, pending_any, overflow_err, spurious_err and starve are 0.
  - post_ready is all-ones.
- Counter state: per client, a saturating counter count[i] of CNT_W bits.
  - acc = post[i] & post_ready[i].
  - ret = grant[i] & request[i].
  - Next value: count[i] <= count[i] + acc - ret.
  - acc and ret in the same cycle leave count unchanged.
- Output decode:
  - request and post_ready are combinational decodes of registered count only.
  - There is no combinational path from grant or post to any output.
  - post_ready deliberately ignores a same-cycle grant, so there is no grant->ready loop.
  - At count==DEPTH a post is refused, even if a grant arrives in the same cycle.
- Latency:
  - A post at edge N (count 0) makes request visible after edge N+1.
  - A grant at edge M (count 1) clears request after edge M+1.
  - Back-to-back posts keep request high continuously.
- Request stability: once request[i]=1 it only falls on the cycle after a retiring grant with count[i]==1. This holds by construction.
- Overflow: post[i] with post_ready[i]=0 is dropped, the count is unchanged, and overflow_err sets and stays set until reset.
- Spurious grant:
  - grant[i] with request[i]=0 is ignored (count is never decremented below 0) and sets spurious_err.
  - A non-onehot0 grant also sets spurious_err; each client with request high still retires normally.
- Reset mid-operation: all pending posts are discarded and the counters and flags are cleared on the same edge.

Optional Feature:
- RR_REQ_TRACKER_STARVE_EN defined:
  - Each client has an age counter, $clog2(STARVE_LIMIT+1) bits, saturating at STARVE_LIMIT.
  - The counter increments each cycle that request[i]=1 and ret=0 and stall=0.
  - It clears on ret or when request[i]=0.
  - starve[i] = (age[i] == STARVE_LIMIT), registered.
- RR_REQ_TRACKER_STARVE_EN undefined: no age counters are built and starve is constant 0. The port list is identical in both builds.

Decomposition:
- Package rr_req_pkg holds:
  - default constants CLIENTS_DEF=32, DEPTH_DEF=4;
  - typedef client_vec_t (logic [CLIENTS_DEF-1:0]);
  - a function cnt_width(depth) returning $clog2(depth+1).
- Sub-module rr_req_slot: one client's counter, its ready/request decode and its optional age counter. It is instantiated CLIENTS times in a generate loop.
- The top level adds the error flags and the pending_any OR-reduction.

Test Plan:
- Reset, then post[3]=1 for one cycle -> request=32'h8 on the next cycle; pending_any=1; post_ready[3] stays 1.
- Post client 5 four times (DEPTH=4), then a 5th post -> post_ready[5]=0 after the 4th; the 5th post is dropped; overflow_err=1; count stays 4.
- Client 7 at count=2 receives grant[7] for 2 cycles -> request[7] high through both grant cycles and 0 on the cycle after the second; no errors.
- Client 2 at count=1 gets post[2] and grant[2] in the same cycle -> count stays 1; request[2] stays high.
- grant=32'h10 with request[4]=0, then grant=32'h3 -> counts unchanged for client 4; spurious_err=1 and sticky across later traffic.
- With STARVE_EN and STARVE_LIMIT=64: client 9 requesting, grant=0, stall=0 for 64 cycles -> starve[9]=1. A single cycle of stall=1 delays starve by 1. grant[9] clears starve[9] on the next cycle.
